// File: rtl/axis_stall_detector.sv
// -----------------------------------------------------------------------------
// axis_stall_detector
//
// Watches the handshake of several AXI-stream ports around a kernel and flags
// any port whose kernel-owned side (req) has been waiting on the partner side
// (ack) for STALL_THRESH consecutive cycles. It also remembers which port
// blocked first, so the deadlock monitor can report the root stall.
//
// Ports:
//   clock              rising-edge clock for all state
//   reset              synchronous, active-high reset
//   enable             monitoring enable; 0 holds every port idle
//   inst_idle          kernel idle flag; 1 suppresses all blocking
//   port_req[N]        kernel-owned side (TREADY on inputs, TVALID on outputs)
//   port_ack[N]        partner-owned side (TVALID on inputs, TREADY on outputs)
//   clear_first        single-cycle pulse that clears the first-block capture
//   axis_block_sigs[N] registered per-port blocked flags
//   any_block          registered OR of axis_block_sigs
//   first_block_valid  sticky flag: a first block has been captured
//   first_block_id     index of the first port that blocked
// -----------------------------------------------------------------------------
module axis_stall_detector #(
  parameter int NUM_PORTS    = 2,
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = 16,
  localparam int ID_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 inst_idle,
  input  logic [NUM_PORTS-1:0] port_req,
  input  logic [NUM_PORTS-1:0] port_ack,
  input  logic                 clear_first,
  output logic [NUM_PORTS-1:0] axis_block_sigs,
  output logic                 any_block,
  output logic                 first_block_valid,
  output logic [ID_W-1:0]      first_block_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

  logic [NUM_PORTS-1:0] blocked_next_s;  // port will be BLOCKED after this edge
  logic [NUM_PORTS-1:0] entry_s;         // port enters BLOCKED on this edge
  logic                 entry_any_s;
  logic [ID_W-1:0]      first_id_s;

  logic [NUM_PORTS-1:0] block_r;
  logic                 any_block_r;
  logic                 fb_valid_r;
  logic [ID_W-1:0]      fb_id_r;

  // Monitoring is suspended whenever the kernel is idle or the block is off.
  logic hold_idle_s;
  assign hold_idle_s = ~enable | inst_idle;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             wait_s;

    // A wait needs req high; req low with ack low is not a stall. Any cycle
    // that is not a wait (xfer, or req low) releases the port.
    assign wait_s = port_req[g] & ~port_ack[g];

    // Per-port state and wait-counter register.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_r <= ST_IDLE;
        cnt_r   <= ZERO_C;
      end else begin
        state_r <= state_next_s;
        cnt_r   <= cnt_next_s;
      end
    end

    // Per-port next-state and counter logic; idle/disable overrides all.
    always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      if (hold_idle_s) begin
        state_next_s = ST_IDLE;
        cnt_next_s   = ZERO_C;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (wait_s) begin
              if (THRESH_C == ONE_C) begin
                state_next_s = ST_BLOCKED;
                cnt_next_s   = THRESH_C;
              end else begin
                state_next_s = ST_WAIT;
                cnt_next_s   = ONE_C;
              end
            end else begin
              state_next_s = ST_IDLE;
              cnt_next_s   = ZERO_C;
            end
          end
          ST_WAIT: begin
            if (wait_s) begin
              // cnt stays below THRESH here, so cnt+1 cannot overflow.
              if ((cnt_r + ONE_C) >= THRESH_C) begin
                state_next_s = ST_BLOCKED;
                cnt_next_s   = THRESH_C;
              end else begin
                state_next_s = ST_WAIT;
                cnt_next_s   = cnt_r + ONE_C;
              end
            end else begin
              state_next_s = ST_IDLE;
              cnt_next_s   = ZERO_C;
            end
          end
          ST_BLOCKED: begin
            if (wait_s) begin
              state_next_s = ST_BLOCKED;
              cnt_next_s   = THRESH_C;  // saturate, never wrap
            end else begin
              state_next_s = ST_IDLE;
              cnt_next_s   = ZERO_C;
            end
          end
          default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = ZERO_C;
          end
        endcase
      end
    end

    assign blocked_next_s[g] = (state_next_s == ST_BLOCKED);
    assign entry_s[g]        = blocked_next_s[g] & (state_r != ST_BLOCKED);
  end

  assign entry_any_s = |entry_s;

  // Lowest-index entering port: scan downward so lower indices win.
  always_comb begin
    first_id_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      first_id_s = entry_s[i] ? ID_W'(i) : first_id_s;
    end
  end

  // Registered block flags; driven from next state so they track BLOCKED.
  always_ff @(posedge clock) begin
    if (reset) begin
      block_r     <= '0;
      any_block_r <= 1'b0;
    end else begin
      block_r     <= blocked_next_s;
      any_block_r <= |blocked_next_s;
    end
  end

  // First-block capture; a new entry beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      fb_valid_r <= 1'b0;
      fb_id_r    <= '0;
    end else if (entry_any_s && (!fb_valid_r || clear_first)) begin
      fb_valid_r <= 1'b1;
      fb_id_r    <= first_id_s;
    end else if (clear_first) begin
      fb_valid_r <= 1'b0;
      fb_id_r    <= '0;
    end else begin
      fb_valid_r <= fb_valid_r;
      fb_id_r    <= fb_id_r;
    end
  end

  assign axis_block_sigs   = block_r;
  assign any_block         = any_block_r;
  assign first_block_valid = fb_valid_r;
  assign first_block_id    = fb_id_r;

endmodule

// File: tb/tb_axis_stall_detector.sv
// -----------------------------------------------------------------------------
// tb_axis_stall_detector
//
// Directed bench for axis_stall_detector with NUM_PORTS=2, STALL_THRESH=4.
// Cycle k is the interval after the k-th clock edge following reset release;
// inputs for cycle k are applied 1 time unit after that edge and outputs are
// observed 1 time unit after the next edge (cycle k+1).
// -----------------------------------------------------------------------------
module tb_axis_stall_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       inst_idle;
  logic [1:0] port_req;
  logic [1:0] port_ack;
  logic       clear_first;
  logic [1:0] axis_block_sigs;
  logic       any_block;
  logic       first_block_valid;
  logic [0:0] first_block_id;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  axis_stall_detector #(
    .NUM_PORTS   (2),
    .STALL_THRESH(4),
    .CNT_W       (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .inst_idle        (inst_idle),
    .port_req         (port_req),
    .port_ack         (port_ack),
    .clear_first      (clear_first),
    .axis_block_sigs  (axis_block_sigs),
    .any_block        (any_block),
    .first_block_valid(first_block_valid),
    .first_block_id   (first_block_id)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] eb, input logic ev, input logic eid);
    chk({tag, " blk"}, 32'(axis_block_sigs), 32'(eb));
    chk({tag, " any"}, 32'(any_block), 32'(|eb));
    chk({tag, " fbv"}, 32'(first_block_valid), 32'(ev));
    chk({tag, " fid"}, 32'(first_block_id), 32'(eid));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    reset       = 1'b1;
    enable      = 1'b1;
    inst_idle   = 1'b0;
    port_req    = 2'b00;
    port_ack    = 2'b00;
    clear_first = 1'b0;
    tick();
    tick();
    check_all({tag, " rst"}, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    int k;

    // Port 0 blocks, then releases with an xfer in cycle 6.
    do_reset("A");
    for (int c = 0; c < 9; c++) begin
      port_req = 2'b01;
      port_ack = (c >= 6) ? 2'b01 : 2'b00;
      tick();
      k = cyc;
      check_all("A", (k >= 4 && k <= 6) ? 2'b01 : 2'b00, k >= 4, 1'b0);
    end

    // Port 1: 3 waits, xfer, 3 waits -> never blocks.
    do_reset("B");
    for (int c = 0; c < 8; c++) begin
      port_req = (c <= 6) ? 2'b10 : 2'b00;
      port_ack = (c == 3) ? 2'b10 : 2'b00;
      tick();
      check_all("B", 2'b00, 1'b0, 1'b0);
    end

    // Both ports start waiting together -> lowest index captured.
    do_reset("C");
    for (int c = 0; c < 4; c++) begin
      port_req = 2'b11;
      port_ack = 2'b00;
      tick();
      k = cyc;
      check_all("C", (k >= 4) ? 2'b11 : 2'b00, k >= 4, 1'b0);
    end

    // Port 0 blocked, inst_idle in cycle 8, re-block; enable low in cycle 14.
    do_reset("D");
    for (int c = 0; c < 20; c++) begin
      port_req  = 2'b01;
      port_ack  = 2'b00;
      inst_idle = (c == 8);
      enable    = (c != 14);
      tick();
      k = cyc;
      check_all("D", ((k >= 4 && k <= 8) || (k >= 13 && k <= 14) || k >= 19) ? 2'b01 : 2'b00,
                k >= 4, 1'b0);
    end
    inst_idle = 1'b0;
    enable    = 1'b1;

    // Port 1 blocked, reset pulsed in cycle 10 with wait held.
    do_reset("E");
    for (int c = 0; c < 17; c++) begin
      port_req = 2'b10;
      port_ack = 2'b00;
      reset    = (c == 10);
      tick();
      k = cyc;
      if ((k >= 4 && k <= 10) || k >= 15)
        check_all("E", 2'b10, 1'b1, 1'b1);
      else
        check_all("E", 2'b00, 1'b0, 1'b0);
    end
    reset = 1'b0;

    // clear_first on the same edge port 1 enters BLOCKED, then a lone clear.
    do_reset("F");
    for (int c = 0; c < 9; c++) begin
      port_req    = {(c >= 2), 1'b1};
      port_ack    = 2'b00;
      clear_first = (c == 5) || (c == 7);
      tick();
      k = cyc;
      check_all("F", {(k >= 6), (k >= 4)}, (k >= 4 && k <= 7), (k >= 6 && k <= 7));
    end
    clear_first = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axis_stall_detector.md
AXIS_STALL_DETECTOR -- requirements
Module: axis_stall_detector

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of monitored AXI-stream ports; index 0 is the kernel input stream, index 1 is the kernel output stream.
REQ-002 SHALL have parameter STALL_THRESH, default 16, the number of consecutive wait cycles that declares a port blocked; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the per-port wait counter.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  monitoring enable; 0 holds all ports idle.
REQ-007 inst_idle  input  1  kernel idle flag; 1 suppresses all blocking.
REQ-008 port_req  input  NUM_PORTS  kernel-owned handshake side per port: TREADY for input ports, TVALID for output ports.
REQ-009 port_ack  input  NUM_PORTS  partner-owned handshake side per port: TVALID for input ports, TREADY for output ports.
REQ-010 clear_first  input  1  single-cycle pulse that clears the first-block capture.
REQ-011 axis_block_sigs  output  NUM_PORTS  registered per-port blocked flags, consumed by the deadlock monitor.
REQ-012 any_block  output  1  registered OR of all axis_block_sigs bits.
REQ-013 first_block_valid  output  1  sticky flag: a first block has been captured.
REQ-014 first_block_id  output  clog2(NUM_PORTS), minimum 1  index of the first port that blocked.

Function
REQ-015 Per port i, wait = port_req[i] & ~port_ack[i] and xfer = port_req[i] & port_ack[i], both sampled on each rising edge.
REQ-016 Each port SHALL run an independent FSM with states IDLE, WAIT and BLOCKED, plus a CNT_W-bit wait counter.
REQ-017 IDLE: on wait, go to WAIT with cnt=1; if STALL_THRESH==1, go directly to BLOCKED instead.
REQ-018 WAIT: on wait, cnt+1; when cnt+1 reaches STALL_THRESH, go to BLOCKED.
REQ-019 WAIT: on xfer or ~port_req[i], go to IDLE with cnt=0.
REQ-020 BLOCKED: hold; the counter saturates at STALL_THRESH with no wrap-around.
REQ-021 BLOCKED: on xfer or ~port_req[i], go to IDLE with cnt=0.
REQ-022 ~port_ack with port_req low is not a wait, and the counter SHALL NOT advance on it.
REQ-023 axis_block_sigs[i] SHALL be 1 exactly while port i is in BLOCKED; it is registered, so it rises the cycle after the STALL_THRESH-th consecutive wait sample.
REQ-024 Latency: a continuous wait starting in cycle 0 yields axis_block_sigs[i]=1 from cycle STALL_THRESH.
REQ-025 After a block, the flag SHALL clear one cycle after the releasing xfer is sampled.
REQ-026 enable=0 or inst_idle=1 SHALL force every port to IDLE with cnt=0 on the next edge; this takes priority over all transitions.
REQ-027 any_block SHALL be registered alongside axis_block_sigs, with identical timing.
REQ-028 On the edge where any port enters BLOCKED while first_block_valid=0, first_block_valid SHALL become 1 and first_block_id SHALL capture that port's index.
REQ-029 If several ports enter BLOCKED on the same edge, first_block_id SHALL capture the lowest index.
REQ-030 Once set, first_block_valid and first_block_id SHALL hold until clear_first or reset.
REQ-031 If clear_first and a new block entry occur on the same edge, the new capture SHALL win: valid=1 with the new id.
REQ-032 All ports SHALL update in parallel, with no inter-port dependency other than the first-block capture.

Reset
REQ-033 reset=1 at an edge SHALL set all FSMs to IDLE, all counters to 0, axis_block_sigs=0, any_block=0, first_block_valid=0 and first_block_id=0.
REQ-034 Reset asserted mid-WAIT or mid-BLOCKED SHALL abort that state with no residual count.
REQ-035 Counting SHALL restart from 0 on the first edge after reset deasserts.

Verification (STALL_THRESH=4, NUM_PORTS=2)
REQ-036 Port 0 req=1, ack=0 from cycle 0; ack=1 in cycle 6 -> axis_block_sigs=01 in cycles 4..6, 00 from cycle 7; first_block_valid=1 and id=0 from cycle 4.
REQ-037 Port 1 wait for 3 cycles, then xfer, then 3 more wait cycles -> axis_block_sigs[1] never 1 and cnt returns to 0 after the xfer.
REQ-038 Both ports begin waiting in the same cycle -> axis_block_sigs=11 and any_block=1 at cycle 4; first_block_id=0.
REQ-039 Port 0 blocked, then inst_idle=1 in cycle 8 -> axis_block_sigs=00 from cycle 9; deassert inst_idle with wait held -> re-block 4 cycles later; first_block_id unchanged.
REQ-040 Port 1 blocked, reset pulsed in cycle 10, wait held -> all outputs 0 at cycle 11; re-block at cycle 15 with first_block_valid=1 and id=1.
REQ-041 clear_first pulsed on the same edge port 1 enters BLOCKED (port 0 captured earlier) -> first_block_valid stays 1 and first_block_id=1.
